// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch front end. Owns the PC and drives a
// single-outstanding req/ack instruction bus. It feeds the IF/ID register
// through an output slot backed by a one-entry skid buffer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif

module pc_fetch #(
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h0
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [5:0]             stall_in,
  input  logic                   jump_flush_in,
  input  logic [`ADDR_WIDTH-1:0] jump_addr_in,
  input  logic                   interrupt_flush_in,
  input  logic [`ADDR_WIDTH-1:0] interrupt_addr_in,
  output logic                   ibus_req_out,
  output logic [`ADDR_WIDTH-1:0] ibus_addr_out,
  input  logic                   ibus_ack_in,
  input  logic [`DATA_WIDTH-1:0] ibus_data_in,
  output logic [`DATA_WIDTH-1:0] inst_out,
  output logic [`ADDR_WIDTH-1:0] address_out
);

  // IDLE: no request. WAIT: request out, data kept. DROP: request out, data discarded.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [`ADDR_WIDTH-1:0] r_pc;
  logic [`ADDR_WIDTH-1:0] w_pc_nxt;
  logic [`ADDR_WIDTH-1:0] r_fetch_addr;
  logic [`ADDR_WIDTH-1:0] w_fetch_nxt;

  logic [`DATA_WIDTH-1:0] r_inst;
  logic [`ADDR_WIDTH-1:0] r_addr;
  logic                   r_out_valid;
  logic [`DATA_WIDTH-1:0] r_skid_inst;
  logic [`ADDR_WIDTH-1:0] r_skid_addr;
  logic                   r_skid_valid;

  logic [`DATA_WIDTH-1:0] w_inst_nxt;
  logic [`ADDR_WIDTH-1:0] w_addr_nxt;
  logic                   w_out_valid_nxt;
  logic [`DATA_WIDTH-1:0] w_skid_inst_nxt;
  logic [`ADDR_WIDTH-1:0] w_skid_addr_nxt;
  logic                   w_skid_valid_nxt;

  logic                   w_redirect;
  logic [`ADDR_WIDTH-1:0] w_target;
  logic                   w_consume;
  logic                   w_load_slot;
  logic                   w_ack_ok;
  logic                   w_issue_ok;
  logic [`ADDR_WIDTH-1:0] w_fetch_inc;
  logic                   w_unused_stall;

  // Interrupt wins over jump; acked data is only usable in WAIT without redirect.
  assign w_redirect     = jump_flush_in | interrupt_flush_in;
  assign w_target       = interrupt_flush_in ? interrupt_addr_in : jump_addr_in;
  assign w_consume      = (stall_in[1] == `NOSTOP);
  assign w_load_slot    = (!r_out_valid) | w_consume;
  assign w_ack_ok       = (r_state == S_WAIT) && ibus_ack_in && !w_redirect;
  assign w_issue_ok     = (stall_in[0] == `NOSTOP);
  assign w_fetch_inc    = r_fetch_addr + 32'd4;
  assign w_unused_stall = &{1'b0, stall_in[5:2]};

  assign ibus_req_out  = (r_state != S_IDLE);
  assign ibus_addr_out = r_fetch_addr;
  assign inst_out      = r_inst;
  assign address_out   = r_addr;

  // Output slot / skid next values: skid first, then acked data, else bubble.
  always_comb begin
    w_inst_nxt       = r_inst;
    w_addr_nxt       = r_addr;
    w_out_valid_nxt  = r_out_valid;
    w_skid_inst_nxt  = r_skid_inst;
    w_skid_addr_nxt  = r_skid_addr;
    w_skid_valid_nxt = r_skid_valid;
    if (w_redirect) begin
      w_inst_nxt       = `NOP;
      w_addr_nxt       = {`ADDR_WIDTH{1'b0}};
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_load_slot) begin
      if (r_skid_valid) begin
        w_inst_nxt      = r_skid_inst;
        w_addr_nxt      = r_skid_addr;
        w_out_valid_nxt = 1'b1;
        // Skid drains into the slot; a same-cycle ack refills it.
        if (w_ack_ok) begin
          w_skid_inst_nxt  = ibus_data_in;
          w_skid_addr_nxt  = r_fetch_addr;
          w_skid_valid_nxt = 1'b1;
        end else begin
          w_skid_valid_nxt = 1'b0;
        end
      end else if (w_ack_ok) begin
        w_inst_nxt      = ibus_data_in;
        w_addr_nxt      = r_fetch_addr;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_inst_nxt      = `NOP;
        w_addr_nxt      = {`ADDR_WIDTH{1'b0}};
        w_out_valid_nxt = 1'b0;
      end
    end else begin
      // Slot held by IF/ID stall: an acked word parks in the skid.
      if (w_ack_ok) begin
        w_skid_inst_nxt  = ibus_data_in;
        w_skid_addr_nxt  = r_fetch_addr;
        w_skid_valid_nxt = 1'b1;
      end else begin
        w_skid_valid_nxt = r_skid_valid;
      end
    end
  end

  // Fetch FSM next state plus PC and bus address updates.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fetch_nxt = r_fetch_addr;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (w_issue_ok && !r_skid_valid) begin
          w_fetch_nxt = r_pc;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ibus_ack_in ? S_IDLE : S_DROP;
        end else if (ibus_ack_in) begin
          w_pc_nxt = w_fetch_inc;
          // Back-to-back fetch only while there is room downstream.
          if (!w_skid_valid_nxt && w_issue_ok) begin
            w_fetch_nxt = w_fetch_inc;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (ibus_ack_in) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC, bus address, output slot and skid registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_inst       <= `NOP;
      r_addr       <= {`ADDR_WIDTH{1'b0}};
      r_out_valid  <= 1'b0;
      r_skid_inst  <= `NOP;
      r_skid_addr  <= {`ADDR_WIDTH{1'b0}};
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_nxt;
      r_inst       <= w_inst_nxt;
      r_addr       <= w_addr_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_inst  <= w_skid_inst_nxt;
      r_skid_addr  <= w_skid_addr_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

endmodule
